// File: rtl/piezo_arbiter.sv
// Buzzer arbiter: a single piezo is shared by the alarm melody, the timer
// beep sequence and key clicks. The alarm has priority over the timer, and
// the timer has priority over key clicks. A timer that is preempted or
// blocked by the alarm is remembered and replayed once the alarm ends.
//
// state  | meaning
// IDLE   | no owner, buzzer silent
// ALARM  | buzzer follows the melody generator, delayed by one clock
// T_BEEP | timer beep tone, beep number beep_cnt
// T_GAP  | silence between two timer beeps
// KEY    | key click tone
module piezo_arbiter #(
    parameter int unsigned KEY_DIV    = 500,
    parameter int unsigned TIMER_DIV  = 602,
    parameter int unsigned KEY_LEN    = 50_000,
    parameter int unsigned BEEP_LEN   = 100_000,
    parameter int unsigned GAP_LEN    = 100_000,
    parameter int unsigned BEEP_COUNT = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ALARM_REQ,
    input  logic       ALARM_PIEZO,
    input  logic       TIMER_REQ,
    input  logic       KEY_REQ,
    output logic       PIEZO,
    output logic [1:0] GRANT,
    output logic       BUSY,
    output logic       TIMER_PEND
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALARM  = 3'd1,
        T_BEEP = 3'd2,
        T_GAP  = 3'd3,
        KEY    = 3'd4
    } state_t;

    localparam logic [15:0] KEY_DIV_C   = 16'(KEY_DIV);
    localparam logic [15:0] TIMER_DIV_C = 16'(TIMER_DIV);
    localparam logic [31:0] KEY_LAST    = 32'(KEY_LEN - 1);
    localparam logic [31:0] BEEP_LAST   = 32'(BEEP_LEN - 1);
    localparam logic [31:0] GAP_LAST    = 32'(GAP_LEN - 1);
    localparam logic [2:0]  LAST_BEEP   = 3'(BEEP_COUNT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] dur_cnt;
    logic [15:0] tone_cnt;
    logic [2:0]  beep_cnt;
    logic [15:0] tone_div;

    assign tone_div = (state == KEY) ? KEY_DIV_C : TIMER_DIV_C;

    function automatic logic [1:0] grant_of(input state_t s);
        case (s)
            ALARM:         grant_of = 2'b11;
            T_BEEP, T_GAP: grant_of = 2'b10;
            KEY:           grant_of = 2'b01;
            default:       grant_of = 2'b00;
        endcase
    endfunction

    // Next owner: alarm level wins everywhere, then the timer, then key clicks.
    always_comb begin
        state_nxt = state;
        if (ALARM_REQ) begin
            state_nxt = ALARM;
        end else begin
            case (state)
                IDLE: begin
                    if (TIMER_REQ)    state_nxt = T_BEEP;
                    else if (KEY_REQ) state_nxt = KEY;
                end
                ALARM: begin
                    // A timer expiring on the same edge the alarm drops is
                    // served directly instead of going through the pending flag.
                    if (TIMER_PEND || TIMER_REQ) state_nxt = T_BEEP;
                    else                         state_nxt = IDLE;
                end
                T_BEEP: begin
                    if (dur_cnt == BEEP_LAST)
                        state_nxt = (beep_cnt < LAST_BEEP) ? T_GAP : IDLE;
                end
                T_GAP: begin
                    if (dur_cnt == GAP_LAST) state_nxt = T_BEEP;
                end
                KEY: begin
                    if (TIMER_REQ)                state_nxt = T_BEEP;
                    else if (dur_cnt == KEY_LAST) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, registered outputs, tone/duration counters and timer bookkeeping.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            GRANT      <= 2'b00;
            BUSY       <= 1'b0;
            PIEZO      <= 1'b0;
            TIMER_PEND <= 1'b0;
            dur_cnt    <= '0;
            tone_cnt   <= '0;
            beep_cnt   <= '0;
        end else begin
            state <= state_nxt;
            GRANT <= grant_of(state_nxt);
            BUSY  <= (state_nxt != IDLE);

            // Every transition restarts the tone phase and duration from silence.
            if (state_nxt != state) begin
                dur_cnt  <= '0;
                tone_cnt <= '0;
                PIEZO    <= 1'b0;
            end else begin
                case (state)
                    ALARM: PIEZO <= ALARM_PIEZO;
                    T_BEEP, KEY: begin
                        dur_cnt <= dur_cnt + 32'd1;
                        if (tone_cnt == tone_div) begin
                            tone_cnt <= '0;
                            PIEZO    <= ~PIEZO;
                        end else begin
                            tone_cnt <= tone_cnt + 16'd1;
                        end
                    end
                    T_GAP:   dur_cnt <= dur_cnt + 32'd1;
                    default: ;
                endcase
            end

            // beep_cnt only survives while the timer sequence owns the buzzer.
            if (state_nxt != T_BEEP && state_nxt != T_GAP)
                beep_cnt <= '0;
            else if (state == T_BEEP && state_nxt == T_GAP)
                beep_cnt <= beep_cnt + 3'd1;
            else if (state_nxt == T_BEEP && state != T_GAP && state != T_BEEP)
                beep_cnt <= '0;

            // The pending flag records a timer lost to the alarm; it is
            // consumed when the alarm releases the buzzer.
            if (ALARM_REQ) begin
                if (TIMER_REQ || state == T_BEEP || state == T_GAP)
                    TIMER_PEND <= 1'b1;
            end else if (state == ALARM) begin
                TIMER_PEND <= 1'b0;
            end
        end
    end

endmodule
